// File: rtl/spike_input_arbiter_if.sv
// ============================================================================
// spike_input_arbiter_if
// Source-side spike handshake plus controller-side head-of-queue signals.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface spike_input_arbiter_if #(
  parameter int N_SRC = 4,
  parameter int IW    = 14,
  parameter int LW    = 4
);
  logic [N_SRC-1:0]    src_valid;
  logic [N_SRC*IW-1:0] src_index;
  logic [N_SRC-1:0]    src_ready;
  logic                input_occurred;
  logic [IW-1:0]       input_index;
  logic                input_ack;
  logic [LW-1:0]       fifo_level;
  logic [15:0]         accept_count;
  logic                protocol_err;

  modport master (
    output src_valid, src_index, input_ack,
    input  src_ready, input_occurred, input_index, fifo_level, accept_count, protocol_err
  );

  modport slave (
    input  src_valid, src_index, input_ack,
    output src_ready, input_occurred, input_index, fifo_level, accept_count, protocol_err
  );
endinterface

`default_nettype wire

// File: rtl/spike_input_arbiter.sv
// ============================================================================
// spike_input_arbiter
// Round-robin arbiter merging N_SRC spike sources into a pending-spike FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spike_input_arbiter #(
  parameter int N_SRC      = 4,
  parameter int SR_DEPTH   = 16384,
  parameter int FIFO_DEPTH = 8
) (
  input  wire logic            clk,
  input  wire logic            reset,
  spike_input_arbiter_if.slave bus
);
  localparam int IW = $clog2(SR_DEPTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [PW-1:0]    rr_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic [15:0]      accept_cnt;
  logic             perr;
  logic [IW-1:0]    mem [FIFO_DEPTH];

  logic             found;
  logic [PW-1:0]    gsel;
  logic [N_SRC-1:0] ready;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [IW-1:0]    push_idx;

  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);

  // Search from rr_ptr upward; no grant while full even if a pop is in flight.
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    ready = '0;
    if (!reset && !full) begin
      for (int k = 0; k < N_SRC; k++) begin
        if (!found && bus.src_valid[(int'(rr_ptr) + k) % N_SRC]) begin
          found = 1'b1;
          gsel  = PW'((int'(rr_ptr) + k) % N_SRC);
        end
      end
    end
    if (found) ready[gsel] = 1'b1;
  end

  assign push     = found;
  assign pop      = bus.input_ack && !empty;
  assign push_idx = bus.src_index[int'(gsel)*IW +: IW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      accept_cnt <= '0;
      perr       <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= (gsel == PW'(N_SRC - 1)) ? '0 : gsel + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
        if (accept_cnt != 16'hFFFF) accept_cnt <= accept_cnt + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (bus.input_ack && empty) perr <= 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is deliberately left out of reset; only pointers and level matter.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_idx;
  end

  assign bus.src_ready      = ready;
  assign bus.input_occurred = !empty;
  assign bus.input_index    = empty ? '0 : mem[rd_ptr];
  assign bus.fifo_level     = level;
  assign bus.accept_count   = accept_cnt;
  assign bus.protocol_err   = perr;
endmodule

`default_nettype wire

// File: tb/tb_spike_input_arbiter.sv
// ============================================================================
// tb_spike_input_arbiter
// Self-checking bench: vector table, corner sequences and randomized traffic.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spike_input_arbiter;
  localparam int N  = 4;
  localparam int IW = 14;
  localparam int D  = 8;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spike_input_arbiter_if #(.N_SRC(N), .IW(IW), .LW(LW)) bus ();

  spike_input_arbiter #(.N_SRC(N), .SR_DEPTH(16384), .FIFO_DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0]    valid;
    logic [N*IW-1:0] idx;
    logic            ack;
    logic [N-1:0]    ready;
    logic            occ;
    logic [IW-1:0]   index;
    logic [LW-1:0]   level;
  } vec_t;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: plain queue of pending indices plus round-robin start.
  int        q[$];
  int        rr;
  int        cnt;
  bit        perr;
  logic [N-1:0]    pend_g;
  logic [N*IW-1:0] pend_idx;
  logic            pend_ack;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  function automatic logic [N*IW-1:0] pack(input int a0, input int a1, input int a2, input int a3);
    logic [N*IW-1:0] p;
    p = '0;
    p[0*IW +: IW] = IW'(a0);
    p[1*IW +: IW] = IW'(a1);
    p[2*IW +: IW] = IW'(a2);
    p[3*IW +: IW] = IW'(a3);
    return p;
  endfunction

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v);
    logic [N-1:0] g;
    g = '0;
    if (q.size() < D) begin
      for (int k = 0; k < N; k++) begin
        if (g == '0 && v[(rr + k) % N]) g[(rr + k) % N] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    q.delete();
    rr   = 0;
    cnt  = 0;
    perr = 0;
  endtask

  // Called just after a negedge: drive, then compare outputs against the model.
  task automatic set_inputs(input logic [N-1:0] v, input logic [N*IW-1:0] ix, input logic ack);
    bus.src_valid = v;
    bus.src_index = ix;
    bus.input_ack = ack;
    #1;
    pend_g   = model_grant(v);
    pend_idx = ix;
    pend_ack = ack;
    chk("src_ready", 64'(bus.src_ready), 64'(pend_g));
    chk("input_occurred", 64'(bus.input_occurred), 64'(q.size() != 0));
    chk("input_index", 64'(bus.input_index), (q.size() != 0) ? 64'(q[0]) : 64'd0);
    chk("fifo_level", 64'(bus.fifo_level), 64'(q.size()));
    chk("accept_count", 64'(bus.accept_count), 64'(cnt));
    chk("protocol_err", 64'(bus.protocol_err), 64'(perr));
  endtask

  task automatic clock_edge();
    int was;
    @(posedge clk);
    was = q.size();
    if (pend_ack) begin
      if (was > 0) void'(q.pop_front());
      else perr = 1;
    end
    for (int i = 0; i < N; i++) begin
      if (pend_g[i]) begin
        q.push_back(int'(pend_idx[i*IW +: IW]));
        rr = (i + 1) % N;
        if (cnt < 65535) cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [N*IW-1:0] ix, input logic ack);
    set_inputs(v, ix, ack);
    clock_edge();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t tbl[9];
  logic [N*IW-1:0] rr_bus;
  logic [N-1:0]    rr_exp[10];

  initial begin
    rr_bus = pack(10, 11, 12, 13);
    tbl[0] = '{4'b0100, pack(0, 0, 123, 0), 1'b0, 4'b0100, 1'b0, 14'd0,   4'd0};
    tbl[1] = '{4'b0000, pack(0, 0, 0, 0),   1'b0, 4'b0000, 1'b1, 14'd123, 4'd1};
    tbl[2] = '{4'b0000, pack(0, 0, 0, 0),   1'b1, 4'b0000, 1'b1, 14'd123, 4'd1};
    tbl[3] = '{4'b0000, pack(0, 0, 0, 0),   1'b0, 4'b0000, 1'b0, 14'd0,   4'd0};
    tbl[4] = '{4'b1111, rr_bus,             1'b0, 4'b1000, 1'b0, 14'd0,   4'd0};
    tbl[5] = '{4'b1111, rr_bus,             1'b0, 4'b0001, 1'b1, 14'd13,  4'd1};
    tbl[6] = '{4'b0000, rr_bus,             1'b1, 4'b0000, 1'b1, 14'd13,  4'd2};
    tbl[7] = '{4'b0000, rr_bus,             1'b1, 4'b0000, 1'b1, 14'd10,  4'd1};
    tbl[8] = '{4'b0000, rr_bus,             1'b0, 4'b0000, 1'b0, 14'd0,   4'd0};
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};

    reset         = 1'b1;
    bus.src_valid = 4'b1111;
    bus.src_index = rr_bus;
    bus.input_ack = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_src_ready", 64'(bus.src_ready), 64'd0);
    chk("reset_occurred", 64'(bus.input_occurred), 64'd0);
    chk("reset_level", 64'(bus.fifo_level), 64'd0);
    chk("reset_index", 64'(bus.input_index), 64'd0);
    chk("reset_count", 64'(bus.accept_count), 64'd0);
    chk("reset_perr", 64'(bus.protocol_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single spike followed by a short round-robin exchange.
    for (int i = 0; i < 9; i++) begin
      set_inputs(tbl[i].valid, tbl[i].idx, tbl[i].ack);
      chk("tbl_ready", 64'(bus.src_ready), 64'(tbl[i].ready));
      chk("tbl_occurred", 64'(bus.input_occurred), 64'(tbl[i].occ));
      chk("tbl_index", 64'(bus.input_index), 64'(tbl[i].index));
      chk("tbl_level", 64'(bus.fifo_level), 64'(tbl[i].level));
      clock_edge();
    end

    // All sources valid, no acks: fixed grant rotation until full.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_inputs(4'b1111, rr_bus, 1'b0);
      chk("rr_order", 64'(bus.src_ready), 64'(rr_exp[i]));
      clock_edge();
    end
    set_inputs(4'b0000, rr_bus, 1'b0);
    chk("rr_full_level", 64'(bus.fifo_level), 64'd8);

    // Pop while full: no grant in the same cycle, grant the next.
    set_inputs(4'b0001, rr_bus, 1'b1);
    chk("full_no_grant", 64'(bus.src_ready), 64'd0);
    clock_edge();
    set_inputs(4'b0001, rr_bus, 1'b0);
    chk("full_level7", 64'(bus.fifo_level), 64'd7);
    chk("full_next_grant", 64'(bus.src_ready), 64'b0001);
    clock_edge();
    set_inputs(4'b0000, rr_bus, 1'b0);
    chk("full_level8", 64'(bus.fifo_level), 64'd8);

    // Drain, then simultaneous push/pop at level 3.
    for (int i = 0; i < 8; i++) cycle(4'b0000, rr_bus, 1'b1);
    for (int i = 0; i < 3; i++) cycle(4'b0001, pack(100 + i, 0, 0, 0), 1'b0);
    cycle(4'b0010, pack(0, 200, 0, 0), 1'b1);
    set_inputs(4'b0000, rr_bus, 1'b0);
    chk("pushpop_level3", 64'(bus.fifo_level), 64'd3);
    for (int i = 0; i < 20; i++) begin
      logic [N-1:0] v;
      v = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
      cycle(v, pack(300 + i, 400 + i, 500 + i, 600 + i), (q.size() > 0) && v != 0);
    end

    // Spurious ack on an empty queue is sticky until reset.
    for (int i = 0; i < 12; i++) cycle(4'b0000, rr_bus, 1'b1);
    for (int i = 0; i < 3; i++) cycle(4'b0000, rr_bus, 1'b0);
    set_inputs(4'b0000, rr_bus, 1'b0);
    chk("perr_sticky", 64'(bus.protocol_err), 64'd1);
    chk("perr_level0", 64'(bus.fifo_level), 64'd0);

    // Asynchronous reset with level 5 and rr_ptr at 2.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(4'b1111, rr_bus, 1'b0);
    cycle(4'b1111, rr_bus, 1'b1);
    set_inputs(4'b1111, rr_bus, 1'b0);
    chk("pre_reset_level5", 64'(bus.fifo_level), 64'd5);
    chk("pre_reset_rr2", 64'(bus.src_ready), 64'b0100);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_occ", 64'(bus.input_occurred), 64'd0);
    chk("async_rst_level", 64'(bus.fifo_level), 64'd0);
    chk("async_rst_ready", 64'(bus.src_ready), 64'd0);
    chk("async_rst_perr", 64'(bus.protocol_err), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_inputs(4'b1111, rr_bus, 1'b0);
    chk("post_reset_grant0", 64'(bus.src_ready), 64'b0001);
    clock_edge();

    // Randomized traffic with varying ack pressure.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0]    v;
      logic [N*IW-1:0] ix;
      int              rate;
      rate = (i / 150) % 2 == 0 ? 4 : 1;
      v  = 4'($urandom);
      ix = pack($urandom_range(0, 16383), $urandom_range(0, 16383),
                $urandom_range(0, 16383), $urandom_range(0, 16383));
      cycle(v, ix, $urandom_range(0, rate) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/spike_input_arbiter.md
SPIKE_INPUT_ARBITER -- requirements
Module: spike_input_arbiter

Interface
REQ-001 Parameter N_SRC, default 4: number of presynaptic spike sources sharing the controller input port.
REQ-002 Parameter SR_DEPTH, default 16384: synapse SRAM depth; index width IW = $clog2(SR_DEPTH).
REQ-003 Parameter FIFO_DEPTH, default 8 (power of 2, >=2): pending-spike queue depth.
REQ-004 Port clk  in  1: single clock; all state updates on posedge clk.
REQ-005 Port reset  in  1: asynchronous, active-high reset.
REQ-006 Port src_valid  in  N_SRC: per-source spike request.
REQ-007 Port src_index  in  N_SRC*IW: source i presynaptic index at bits [i*IW +: IW].
REQ-008 Port src_ready  out  N_SRC: one-hot-or-zero grant; a spike transfers when src_valid[i] & src_ready[i].
REQ-009 Port input_occurred  out  1: queued spike pending, driven to network controller.
REQ-010 Port input_index  out  IW: index of head spike, driven to network controller.
REQ-011 Port input_ack  in  1: controller registered the head spike (single-cycle pulse).
REQ-012 Port fifo_level  out  $clog2(FIFO_DEPTH)+1: current queue occupancy.
REQ-013 Port accept_count  out  16: saturating count of spikes accepted from sources.
REQ-014 Port protocol_err  out  1: sticky flag, input_ack received while queue empty.

Function
REQ-015 src_ready SHALL be combinational from src_valid, rr_ptr and fifo_level; at most one bit high per cycle.
REQ-016 src_ready SHALL be all-zero when fifo_level == FIFO_DEPTH, regardless of pops in the same cycle (no full bypass).
REQ-017 Grant SHALL go to the first i with src_valid[i]=1 searching rr_ptr, rr_ptr+1, ... modulo N_SRC.
REQ-018 On a transfer from source g, rr_ptr SHALL become (g+1) mod N_SRC next cycle; otherwise rr_ptr holds.
REQ-019 A transfer SHALL push src_index of source g into the FIFO tail; spike visible at head no earlier than the next cycle.
REQ-020 input_occurred SHALL equal (fifo_level != 0); input_index SHALL equal head entry, registered/stable until popped.
REQ-021 input_ack=1 with fifo_level != 0 SHALL pop the head at that clock edge.
REQ-022 input_ack=1 with fifo_level == 0 SHALL not change the queue and SHALL set protocol_err until reset.
REQ-023 Simultaneous push and pop SHALL leave fifo_level unchanged and preserve FIFO order.
REQ-024 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 accept_count SHALL increment by 1 per transfer and saturate at 16'hFFFF.
REQ-026 input_occurred SHALL remain asserted across cycles without input_ack; the block SHALL tolerate controller ack latency of any number of cycles.
REQ-027 Spikes SHALL never be dropped; back-pressure to sources via src_ready is the only flow control.

Reset
REQ-028 While reset is high: FIFO empty, fifo_level=0, rr_ptr=0, accept_count=0, protocol_err=0, input_occurred=0, input_index=0, src_ready=0.
REQ-029 Reset asserted mid-operation SHALL discard all queued spikes immediately (asynchronous); first grant after release starts from source 0.
REQ-030 FIFO storage contents need not be reset; only pointers and level.

Verification
REQ-031 Single spike: src_valid=4'b0100, index 123 for one cycle -> src_ready=4'b0100, next cycle input_occurred=1, input_index=123; ack -> input_occurred=0, accept_count=1.
REQ-032 Round-robin: all four sources valid continuously, no acks, indices 10/11/12/13 -> grants in order 0,1,2,3,0,1,2,3; fifo_level reaches 8, src_ready=0 thereafter.
REQ-033 Full boundary: fifo_level=8, input_ack=1, src_valid=4'b0001 same cycle -> no grant that cycle, level 7; grant next cycle, level 8.
REQ-034 Simultaneous push/pop at level 3 -> level stays 3; popped order matches push order over 20 random ops.
REQ-035 Spurious ack with empty queue -> protocol_err=1, fifo_level=0; stays 1 until reset.
REQ-036 Reset with level 5, rr_ptr=2 -> input_occurred=0, fifo_level=0 immediately; after release, src_valid=4'b1111 grants source 0 first.
